// File: rtl/jzjpcc_pkg.sv
// Shared RV32I decode definitions: opcodes, NOP word, immediate formats
// and the ID/EX bundle carried between decode and execute.
package jzjpcc_pkg;

    localparam logic [31:0] RV_NOP = 32'h00000013;

    localparam logic [6:0] OPC_LUI     = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
    localparam logic [6:0] OPC_JAL     = 7'b1101111;
    localparam logic [6:0] OPC_JALR    = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
    localparam logic [6:0] OPC_LOAD    = 7'b0000011;
    localparam logic [6:0] OPC_STORE   = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP      = 7'b0110011;
    localparam logic [6:0] OPC_MISCMEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [4:0]  rdAddr;
        logic        rdWrite;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5;
        logic        isLoad;
        logic        illegal;
    } id_ex_t;

    // Format is chosen from opcode[6:2]; opcode[1:0] legality is checked by the caller.
    function automatic imm_fmt_t immFormat(input logic [4:0] op5);
        imm_fmt_t fmt;
        fmt = IMM_NONE;
        if (op5 == OPC_LUI[6:2] || op5 == OPC_AUIPC[6:2])
            fmt = IMM_U;
        else if (op5 == OPC_JAL[6:2])
            fmt = IMM_J;
        else if (op5 == OPC_BRANCH[6:2])
            fmt = IMM_B;
        else if (op5 == OPC_STORE[6:2])
            fmt = IMM_S;
        else if (op5 == OPC_JALR[6:2] || op5 == OPC_LOAD[6:2] ||
                 op5 == OPC_OPIMM[6:2] || op5 == OPC_MISCMEM[6:2] ||
                 op5 == OPC_SYSTEM[6:2])
            fmt = IMM_I;
        return fmt;
    endfunction

    function automatic logic isBaseOpcode(input logic [6:0] op);
        return op == OPC_LUI    || op == OPC_AUIPC  || op == OPC_JAL   ||
               op == OPC_JALR   || op == OPC_BRANCH || op == OPC_LOAD  ||
               op == OPC_STORE  || op == OPC_OPIMM  || op == OPC_OP    ||
               op == OPC_MISCMEM || op == OPC_SYSTEM;
    endfunction

endpackage

// File: rtl/jzjpcc_immediateFormer.sv
// Combinational RV32I immediate extraction (I/S/B/U/J), sign-extended.
module jzjpcc_immediateFormer
    import jzjpcc_pkg::*;
(
    input  logic [31:2] instruction_i,
    output logic [31:0] immediate_o
);

    logic [31:0] ins;
    imm_fmt_t    fmt;

    assign ins = {instruction_i, 2'b11};
    assign fmt = immFormat(instruction_i[6:2]);

    always_comb begin
        immediate_o = '0;
        unique case (fmt)
            IMM_I: immediate_o = {{20{ins[31]}}, ins[31:20]};
            IMM_S: immediate_o = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            IMM_B: immediate_o = {{19{ins[31]}}, ins[31], ins[7],
                                  ins[30:25], ins[11:8], 1'b0};
            IMM_U: immediate_o = {ins[31:12], 12'b0};
            IMM_J: immediate_o = {{11{ins[31]}}, ins[31], ins[19:12],
                                  ins[20], ins[30:21], 1'b0};
            default: immediate_o = '0;
        endcase
    end

endmodule

// File: rtl/jzjpcc_decode_stage.sv
// IF/ID register plus RV32I decode, load-use interlock and WB bypass
// feeding the registered ID/EX bundle.
module jzjpcc_decode_stage
    import jzjpcc_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = jzjpcc_pkg::RV_NOP
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] fetchInstruction,
    input  logic [31:0] fetchPC,
    input  logic        fetchValid,
    output logic        stallFetch,
    input  logic        flush,
    input  logic        exStall,
    output logic [4:0]  rs1Addr,
    output logic [4:0]  rs2Addr,
    input  logic [31:0] rs1Data,
    input  logic [31:0] rs2Data,
    input  logic [4:0]  wbRdAddr,
    input  logic [31:0] wbRdData,
    input  logic        wbWriteEn,
    output logic        idexValid,
    output logic [31:0] idexPC,
    output logic [31:0] idexRs1,
    output logic [31:0] idexRs2,
    output logic [31:0] idexImm,
    output logic [4:0]  idexRdAddr,
    output logic        idexRdWrite,
    output logic [6:0]  idexOpcode,
    output logic [2:0]  idexFunct3,
    output logic        idexFunct7b5,
    output logic        idexIsLoad,
    output logic        idexIllegal
);

    logic        ifidValid_q, ifidValid_d;
    logic [31:0] ifidInstr_q, ifidInstr_d;
    logic [31:0] ifidPc_q, ifidPc_d;
    id_ex_t      idex_q, idex_d;

    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [31:0] immRaw;
    logic        illegal;
    logic        rs1Used, rs2Used;
    logic        rdWrites;
    logic        loadUse;
    logic        hold;
    logic [31:0] rs1Op, rs2Op;

    assign opcode  = ifidInstr_q[6:0];
    assign rd      = ifidInstr_q[11:7];
    assign rs1Addr = ifidInstr_q[19:15];
    assign rs2Addr = ifidInstr_q[24:20];

    jzjpcc_immediateFormer u_imm (
        .instruction_i (ifidInstr_q[31:2]),
        .immediate_o   (immRaw)
    );

    assign illegal = (opcode[1:0] != 2'b11) || !isBaseOpcode(opcode);
    assign rs1Used = !(opcode == OPC_LUI || opcode == OPC_AUIPC ||
                       opcode == OPC_JAL);
    assign rs2Used = opcode == OPC_BRANCH || opcode == OPC_STORE ||
                     opcode == OPC_OP;
    assign rdWrites = (rd != 5'd0) &&
                      (opcode == OPC_LUI  || opcode == OPC_AUIPC ||
                       opcode == OPC_JAL  || opcode == OPC_JALR  ||
                       opcode == OPC_LOAD || opcode == OPC_OPIMM ||
                       opcode == OPC_OP);

    assign loadUse = ifidValid_q && idex_q.valid && idex_q.isLoad &&
                     (idex_q.rdAddr != 5'd0) &&
                     ((rs1Used && rs1Addr == idex_q.rdAddr) ||
                      (rs2Used && rs2Addr == idex_q.rdAddr));
    assign hold       = loadUse || exStall;
    assign stallFetch = hold;

    // Writeback in the same cycle beats the stale regfile read.
    assign rs1Op = (wbWriteEn && wbRdAddr != 5'd0 && wbRdAddr == rs1Addr)
                   ? wbRdData : rs1Data;
    assign rs2Op = (wbWriteEn && wbRdAddr != 5'd0 && wbRdAddr == rs2Addr)
                   ? wbRdData : rs2Data;

    always_comb begin
        ifidValid_d = ifidValid_q;
        ifidInstr_d = ifidInstr_q;
        ifidPc_d    = ifidPc_q;
        if (flush) begin
            ifidValid_d = 1'b0;
            ifidInstr_d = NOP_INSTR;
        end else if (!hold) begin
            ifidValid_d = fetchValid;
            ifidInstr_d = fetchInstruction;
            ifidPc_d    = fetchPC;
        end
    end

    always_comb begin
        idex_d = idex_q;
        if (flush || (!exStall && loadUse)) begin
            idex_d.valid   = 1'b0;
            idex_d.rdWrite = 1'b0;
            idex_d.isLoad  = 1'b0;
        end else if (!exStall) begin
            idex_d.valid    = ifidValid_q;
            idex_d.pc       = ifidPc_q;
            idex_d.rs1      = rs1Op;
            idex_d.rs2      = rs2Op;
            idex_d.imm      = (illegal || opcode == OPC_OP) ? '0 : immRaw;
            idex_d.rdAddr   = rd;
            idex_d.rdWrite  = rdWrites;
            idex_d.opcode   = opcode;
            idex_d.funct3   = ifidInstr_q[14:12];
            idex_d.funct7b5 = ifidInstr_q[30];
            idex_d.isLoad   = opcode == OPC_LOAD;
            idex_d.illegal  = illegal;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ifidValid_q <= 1'b0;
            ifidInstr_q <= NOP_INSTR;
            ifidPc_q    <= '0;
            idex_q      <= '0;
        end else begin
            ifidValid_q <= ifidValid_d;
            ifidInstr_q <= ifidInstr_d;
            ifidPc_q    <= ifidPc_d;
            idex_q      <= idex_d;
        end
    end

    assign idexValid    = idex_q.valid;
    assign idexPC       = idex_q.pc;
    assign idexRs1      = idex_q.rs1;
    assign idexRs2      = idex_q.rs2;
    assign idexImm      = idex_q.imm;
    assign idexRdAddr   = idex_q.rdAddr;
    assign idexRdWrite  = idex_q.rdWrite;
    assign idexOpcode   = idex_q.opcode;
    assign idexFunct3   = idex_q.funct3;
    assign idexFunct7b5 = idex_q.funct7b5;
    assign idexIsLoad   = idex_q.isLoad;
    assign idexIllegal  = idex_q.illegal;

endmodule

// File: tb/tb_jzjpcc_decode_stage.sv
// Directed bench for jzjpcc_decode_stage with hand-computed expectations.
module tb_jzjpcc_decode_stage;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] fetchInstruction = 32'h00000013;
    logic [31:0] fetchPC = '0;
    logic        fetchValid = 1'b0;
    logic        stallFetch;
    logic        flush = 1'b0;
    logic        exStall = 1'b0;
    logic [4:0]  rs1Addr, rs2Addr;
    logic [31:0] rs1Data = '0;
    logic [31:0] rs2Data = '0;
    logic [4:0]  wbRdAddr = '0;
    logic [31:0] wbRdData = '0;
    logic        wbWriteEn = 1'b0;
    logic        idexValid;
    logic [31:0] idexPC, idexRs1, idexRs2, idexImm;
    logic [4:0]  idexRdAddr;
    logic        idexRdWrite;
    logic [6:0]  idexOpcode;
    logic [2:0]  idexFunct3;
    logic        idexFunct7b5, idexIsLoad, idexIllegal;

    int total = 0;
    int bad = 0;

    localparam logic [31:0] ADDI_X1 = 32'h00500093;
    localparam logic [31:0] LW_X2   = 32'h0000A103;
    localparam logic [31:0] ADD_X3  = 32'h002101B3;
    localparam logic [31:0] ADDI_X6 = 32'h00128313;
    localparam logic [31:0] BEQ_M4  = 32'hFE000EE3;
    localparam logic [31:0] NOP     = 32'h00000013;

    jzjpcc_decode_stage dut (
        .clock(clock), .reset(reset),
        .fetchInstruction(fetchInstruction), .fetchPC(fetchPC),
        .fetchValid(fetchValid), .stallFetch(stallFetch),
        .flush(flush), .exStall(exStall),
        .rs1Addr(rs1Addr), .rs2Addr(rs2Addr),
        .rs1Data(rs1Data), .rs2Data(rs2Data),
        .wbRdAddr(wbRdAddr), .wbRdData(wbRdData), .wbWriteEn(wbWriteEn),
        .idexValid(idexValid), .idexPC(idexPC),
        .idexRs1(idexRs1), .idexRs2(idexRs2), .idexImm(idexImm),
        .idexRdAddr(idexRdAddr), .idexRdWrite(idexRdWrite),
        .idexOpcode(idexOpcode), .idexFunct3(idexFunct3),
        .idexFunct7b5(idexFunct7b5), .idexIsLoad(idexIsLoad),
        .idexIllegal(idexIllegal)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [31:0] ins, input logic [31:0] pc,
                         input logic v);
        fetchInstruction = ins;
        fetchPC = pc;
        fetchValid = v;
    endtask

    initial begin
        // async reset from power-up, before any clock edge
        #2 reset = 1'b1;
        #1;
        chk("rst_valid", {31'b0, idexValid}, 32'd0);
        chk("rst_pc", idexPC, 32'd0);
        chk("rst_imm", idexImm, 32'd0);
        chk("rst_ifid", dut.ifidInstr_q, NOP);
        chk("rst_stall", {31'b0, stallFetch}, 32'd0);
        step();
        reset = 1'b0;

        // ADDI x1,x0,5 at 0x100
        fetch(ADDI_X1, 32'h100, 1'b1);
        step();
        chk("addi_rs2addr", {27'b0, rs2Addr}, 32'd5);
        fetch(NOP, 32'h104, 1'b0);
        step();
        chk("addi_valid", {31'b0, idexValid}, 32'd1);
        chk("addi_imm", idexImm, 32'd5);
        chk("addi_rd", {27'b0, idexRdAddr}, 32'd1);
        chk("addi_rdw", {31'b0, idexRdWrite}, 32'd1);
        chk("addi_pc", idexPC, 32'h100);
        chk("addi_op", {25'b0, idexOpcode}, 32'h13);
        chk("addi_ill", {31'b0, idexIllegal}, 32'd0);

        // load-use: LW x2 then ADD x3,x2,x2
        rs1Data = 32'h11;
        rs2Data = 32'h22;
        fetch(LW_X2, 32'h104, 1'b1);
        step();
        fetch(ADD_X3, 32'h108, 1'b1);
        step();
        chk("lw_isload", {31'b0, idexIsLoad}, 32'd1);
        chk("lw_rd", {27'b0, idexRdAddr}, 32'd2);
        chk("lu_stall", {31'b0, stallFetch}, 32'd1);
        fetch(NOP, 32'h10C, 1'b1);
        step();
        chk("lu_bubble", {31'b0, idexValid}, 32'd0);
        chk("lu_bub_rdw", {31'b0, idexRdWrite}, 32'd0);
        chk("lu_bub_ld", {31'b0, idexIsLoad}, 32'd0);
        chk("lu_held", {27'b0, rs1Addr}, 32'd2);
        chk("lu_stall_end", {31'b0, stallFetch}, 32'd0);
        step();
        chk("add_valid", {31'b0, idexValid}, 32'd1);
        chk("add_pc", idexPC, 32'h108);
        chk("add_rd", {27'b0, idexRdAddr}, 32'd3);
        chk("add_imm", idexImm, 32'd0);
        chk("add_rs1", idexRs1, 32'h11);
        chk("add_rs2", idexRs2, 32'h22);
        chk("add_ifid_pc", dut.ifidPc_q, 32'h10C);

        // writeback bypass on rs1=x5
        rs1Data = 32'h0;
        fetch(ADDI_X6, 32'h110, 1'b1);
        step();
        wbWriteEn = 1'b1;
        wbRdAddr = 5'd5;
        wbRdData = 32'hDEADBEEF;
        fetch(ADDI_X6, 32'h114, 1'b1);
        step();
        chk("byp_rs1", idexRs1, 32'hDEADBEEF);
        chk("byp_imm", idexImm, 32'd1);
        wbRdAddr = 5'd0;
        fetch(NOP, 32'h118, 1'b0);
        step();
        chk("byp_x0_rs1", idexRs1, 32'd0);
        chk("byp_x0_pc", idexPC, 32'h114);
        wbWriteEn = 1'b0;

        // BEQ -4 then an all-zero word
        fetch(BEQ_M4, 32'h120, 1'b1);
        step();
        fetch(32'h0, 32'h124, 1'b1);
        step();
        chk("beq_imm", idexImm, 32'hFFFFFFFC);
        chk("beq_rdw", {31'b0, idexRdWrite}, 32'd0);
        chk("beq_ill", {31'b0, idexIllegal}, 32'd0);
        fetch(NOP, 32'h128, 1'b0);
        step();
        chk("zero_ill", {31'b0, idexIllegal}, 32'd1);
        chk("zero_imm", idexImm, 32'd0);
        chk("zero_rdw", {31'b0, idexRdWrite}, 32'd0);

        // exStall holds both registers, then flush with exStall
        fetch(ADDI_X1, 32'h200, 1'b1);
        step();
        fetch(ADD_X3, 32'h204, 1'b1);
        step();
        exStall = 1'b1;
        fetch(NOP, 32'h208, 1'b1);
        #1;
        chk("exs_stallf", {31'b0, stallFetch}, 32'd1);
        step();
        chk("exs_hold_pc", idexPC, 32'h200);
        chk("exs_hold_imm", idexImm, 32'd5);
        chk("exs_hold_ifid", {27'b0, rs1Addr}, 32'd2);
        flush = 1'b1;
        step();
        chk("fl_valid", {31'b0, idexValid}, 32'd0);
        chk("fl_ifid", dut.ifidInstr_q, NOP);
        chk("fl_rs2addr", {27'b0, rs2Addr}, 32'd0);
        flush = 1'b0;
        exStall = 1'b0;

        // async reset in the middle of a stalled cycle
        fetch(ADDI_X1, 32'h300, 1'b1);
        step();
        fetch(NOP, 32'h304, 1'b0);
        step();
        chk("pre_rst_valid", {31'b0, idexValid}, 32'd1);
        exStall = 1'b1;
        fetch(LW_X2, 32'h304, 1'b1);
        step();
        #2 reset = 1'b1;
        #1;
        chk("mid_rst_valid", {31'b0, idexValid}, 32'd0);
        chk("mid_rst_pc", idexPC, 32'd0);
        chk("mid_rst_imm", idexImm, 32'd0);
        chk("mid_rst_rd", {27'b0, idexRdAddr}, 32'd0);
        chk("mid_rst_ifid", dut.ifidInstr_q, NOP);
        reset = 1'b0;
        exStall = 1'b0;
        fetch(ADD_X3, 32'h400, 1'b1);
        step();
        chk("post_rst_ifid", {27'b0, rs1Addr}, 32'd2);
        fetch(NOP, 32'h404, 1'b0);
        step();
        chk("post_rst_pc", idexPC, 32'h400);
        chk("post_rst_valid", {31'b0, idexValid}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jzjpcc_decode_stage.md
JZJPCC_DECODE_STAGE -- requirements
Module: jzjpcc_decode_stage

Interface
REQ-001 Parameter NOP_INSTR, default 32'h00000013, meaning instruction word held in IF/ID at reset or after flush.
REQ-002 clock  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 fetchInstruction  input  32  instruction word from fetch.
REQ-005 fetchPC  input  32  PC of fetchInstruction.
REQ-006 fetchValid  input  1  fetch word valid this cycle.
REQ-007 stallFetch  output  1  fetch SHALL hold its PC while high; combinational.
REQ-008 flush  input  1  branch/jump redirect from EX; kills IF/ID and ID/EX contents.
REQ-009 exStall  input  1  downstream backpressure; ID/EX SHALL hold while high.
REQ-010 rs1Addr, rs2Addr  output  5 each  regfile read addresses, from IF/ID instruction [19:15], [24:20]; combinational.
REQ-011 rs1Data, rs2Data  input  32 each  regfile read data, same cycle.
REQ-012 wbRdAddr  input  5;  wbRdData  input  32;  wbWriteEn  input  1  writeback port for bypass.
REQ-013 idexValid, idexPC[31:0], idexRs1[31:0], idexRs2[31:0], idexImm[31:0], idexRdAddr[4:0], idexRdWrite, idexOpcode[6:0], idexFunct3[2:0], idexFunct7b5, idexIsLoad, idexIllegal  outputs  registered ID/EX fields.

Function
REQ-014 IF/ID register update priority: flush -> valid=0, instr=NOP_INSTR; else hold -> unchanged; else load fetchValid/fetchInstruction/fetchPC.
REQ-015 hold = loadUseHazard OR exStall; stallFetch SHALL equal hold.
REQ-016 rs1Used SHALL be 1 for all opcodes except LUI, AUIPC, JAL; rs2Used SHALL be 1 only for BRANCH, STORE, OP.
REQ-017 loadUseHazard = IF/ID valid AND idexValid AND idexIsLoad AND idexRdAddr!=0 AND ((rs1Used AND rs1Addr==idexRdAddr) OR (rs2Used AND rs2Addr==idexRdAddr)).
REQ-018 ID/EX update priority: flush -> idexValid=0; else exStall -> all fields unchanged; else loadUseHazard -> bubble (idexValid=0, idexRdWrite=0, idexIsLoad=0); else load decoded IF/ID contents.
REQ-019 Bypass: if wbWriteEn AND wbRdAddr!=0 AND wbRdAddr==rsNAddr, operand SHALL be wbRdData, else rsNData.
REQ-020 idexRdWrite SHALL be 1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, and 0 when rd==0 or opcode is BRANCH/STORE/other.
REQ-021 Immediate SHALL be RV32I I/S/B/U/J format per opcode, sign-extended to 32 bits (B and J LSB = 0); 0 for OP and illegal.
REQ-022 idexIllegal SHALL be 1 when opcode[1:0]!=2'b11 or opcode is not an RV32I base opcode (incl. MISC-MEM, SYSTEM as legal).
REQ-023 Latency: instruction accepted from fetch at edge N appears on ID/EX outputs at edge N+1 absent hold/flush.
REQ-024 flush and exStall simultaneous: flush wins in both registers.
REQ-025 Hazard bubble lasts exactly one cycle for a single load-use dependency.

Reset
REQ-026 Reset SHALL asynchronously set IF/ID valid=0, instr=NOP_INSTR, pc=0, and all ID/EX outputs to 0.
REQ-027 Reset asserted mid-stall SHALL discard held instruction; first post-reset edge loads fetch inputs.

Structure
REQ-028 Opcode constants, NOP_INSTR value, and immediate-format enum SHALL reside in shared package jzjpcc_pkg.
REQ-029 Immediate generation SHALL be sub-module jzjpcc_immediateFormer (combinational, instruction[31:2] in, 32-bit immediate out).

Verification
REQ-030 fetch ADDI x1,x0,5 (0x00500093) at PC 0x100 -> next edge idexValid=1, idexImm=5, idexRdAddr=1, idexRdWrite=1, idexPC=0x100.
REQ-031 LW x2,0(x1) then ADD x3,x2,x2 -> stallFetch=1 one cycle, one bubble (idexValid=0), then ADD issues; fetch PC held.
REQ-032 wbWriteEn=1, wbRdAddr=5, wbRdData=0xDEADBEEF, decoding rs1=x5, rs1Data=0 -> idexRs1=0xDEADBEEF; same with wbRdAddr=0 -> idexRs1=0.
REQ-033 flush and exStall asserted together with valid instruction in IF/ID -> next edge idexValid=0 and IF/ID instr=0x00000013.
REQ-034 BEQ with offset -4 (0xFE000EE3) -> idexImm=0xFFFFFFFC, idexRdWrite=0; opcode 7'b0000000 -> idexIllegal=1.
REQ-035 reset asserted asynchronously mid-cycle during exStall -> all ID/EX outputs 0 immediately, without waiting for a clock edge.
